alu_operand_stage: RTL
======================

Name: alu_operand_stage

Overview:
- Sequential issue/writeback stage wrapped around the combinational CustomALU.
- Accepts register-based ALU commands over a valid/ready handshake and holds an internal register file.
- Drives registered SEL/A/B to the ALU and captures the ALU result S one cycle later.
- Writes the result back to the register file and presents it on a result handshake.

Parameters:
- SEL_WIDTH, 3, ALU opcode width; must match the ALU.
- DATA_WIDTH, 32, register and operand width.
- REG_ADDR_WIDTH, 3, register index width; register count = 2**REG_ADDR_WIDTH.
- IMM_WIDTH, 16, immediate width; zero-extended to DATA_WIDTH.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  stage can accept a command.
- CMD_OP  in  SEL_WIDTH  ALU opcode: 0 ADD, 1 SUB, 2 MUL, 3 PAS, 4 AND, 5 OR, 6 XOR, 7 NOT.
- CMD_RD  in  REG_ADDR_WIDTH  destination register.
- CMD_RA  in  REG_ADDR_WIDTH  source register for A.
- CMD_RB  in  REG_ADDR_WIDTH  source register for B (ignored when CMD_IMM_EN=1).
- CMD_IMM_EN  in  1  B = zero-extended CMD_IMM instead of reg[RB].
- CMD_IMM  in  IMM_WIDTH  immediate.
- ALU_SEL  out  SEL_WIDTH  registered opcode to ALU.
- ALU_A  out  DATA_WIDTH  registered operand A.
- ALU_B  out  DATA_WIDTH  registered operand B.
- ALU_S  in  DATA_WIDTH  combinational ALU result.
- RES_VALID  out  1  result available.
- RES_READY  in  1  consumer accepts result.
- RES_DATA  out  DATA_WIDTH  captured result.
- RES_ZERO  out  1  RES_DATA == 0.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State goes to IDLE.
  - All registers are cleared to 0.
  - ALU_SEL/ALU_A/ALU_B/RES_DATA = 0, RES_VALID = 0, RES_ZERO = 1, CMD_READY = 1.
- Register 0 is hardwired to zero: reads return 0 and writes are discarded.
- FSM IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - CMD_READY = 1.
  - On CMD_VALID & CMD_READY: ALU_SEL <= CMD_OP; ALU_A <= reg[RA]; ALU_B <= CMD_IMM_EN ? {0, CMD_IMM} : reg[RB].
  - Latch RD internally; go to EXEC.
- EXEC (exactly 1 cycle):
  - CMD_READY = 0.
  - RES_DATA <= ALU_S; RES_ZERO <= (ALU_S == 0).
  - reg[RD] <= ALU_S unless RD = 0.
  - Go to RESP.
- RESP:
  - RES_VALID = 1; CMD_READY = 0.
  - RES_DATA and RES_ZERO are held stable.
  - On RES_READY go to IDLE, with RES_VALID = 0 next cycle.
- ALU_SEL/A/B hold their values outside IDLE-accept cycles and are never modified in EXEC/RESP.
- Latency: accept edge -> ALU inputs valid next cycle -> RES_VALID asserted 2 cycles after accept. Minimum command period is 3 cycles.
- RES_READY may already be high when RES_VALID rises; the transfer then completes in that same cycle.
- CMD_VALID is ignored while CMD_READY = 0, and commands are never queued.
- Hazards: none, because writeback completes before the next accept, so a following RA/RB = previous RD sees the new value.
- Widths:
  - ALU_S is taken as-is, with no extension or truncation.
  - MUL width semantics (low-half operands) are owned by the ALU; this stage passes full-width operands.
- RST asserted in EXEC or RESP aborts the command: no writeback occurs if reset arrives before the EXEC edge, and the result is lost.

Test Plan:
- Reset; then ADD RD=1 RA=0 IMM_EN IMM=0x0005 -> ALU_SEL=0, A=0, B=5 the cycle after accept; RES_VALID 2 cycles after accept; RES_DATA=0x00000005; RES_ZERO=0.
- SUB RD=2 RA=1 IMM=0x0007 -> RES_DATA=0xFFFFFFFE; then PAS RD=3 RA=2 -> RES_DATA=0xFFFFFFFE, proving the RAW dependency across back-to-back commands.
- ADD RD=0 RA=1 IMM=1 -> RES_DATA=6; then PAS RD=4 RA=0 -> RES_DATA=0, RES_ZERO=1 (r0 stays zero).
- Hold RES_READY=0 for 5 cycles with CMD_VALID=1 -> RES_VALID/RES_DATA stable and CMD_READY=0 throughout; the queued command is accepted only in the cycle after the RES_READY handshake.
- Pulse RST during EXEC of ADD RD=1 RA=1 IMM=0x10 -> all outputs at reset values immediately; subsequent PAS RD=5 RA=1 returns 0.
- RES_READY tied high, CMD_VALID tied high with 4 commands -> CMD_READY high exactly every 3rd cycle; 4 results with correct values in order.

Source files
------------

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: issue/writeback stage wrapped around a combinational ALU.
// It accepts one register-based command at a time, drives registered operands
// to the ALU, captures the ALU result one cycle later, writes it back to the
// internal register file, and presents it on a result handshake.
// Ports:
//   CLK, RST                   clock, asynchronous active-high reset
//   CMD_VALID/CMD_READY        command handshake
//   CMD_OP/RD/RA/RB            opcode, destination and source register indices
//   CMD_IMM_EN/CMD_IMM         select zero-extended immediate for operand B
//   ALU_SEL/ALU_A/ALU_B        registered opcode and operands driven to the ALU
//   ALU_S                      combinational ALU result
//   RES_VALID/RES_READY        result handshake
//   RES_DATA/RES_ZERO          captured result and its zero flag
module alu_operand_stage #(
  parameter int unsigned SEL_WIDTH      = 3,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 3,
  parameter int unsigned IMM_WIDTH      = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      CMD_VALID,
  output logic                      CMD_READY,
  input  logic [SEL_WIDTH-1:0]      CMD_OP,
  input  logic [REG_ADDR_WIDTH-1:0] CMD_RD,
  input  logic [REG_ADDR_WIDTH-1:0] CMD_RA,
  input  logic [REG_ADDR_WIDTH-1:0] CMD_RB,
  input  logic                      CMD_IMM_EN,
  input  logic [IMM_WIDTH-1:0]      CMD_IMM,
  output logic [SEL_WIDTH-1:0]      ALU_SEL,
  output logic [DATA_WIDTH-1:0]     ALU_A,
  output logic [DATA_WIDTH-1:0]     ALU_B,
  input  logic [DATA_WIDTH-1:0]     ALU_S,
  output logic                      RES_VALID,
  input  logic                      RES_READY,
  output logic [DATA_WIDTH-1:0]     RES_DATA,
  output logic                      RES_ZERO
);

  localparam int unsigned NUM_REGS = 2 ** REG_ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                      state;
  logic [DATA_WIDTH-1:0]       regs [NUM_REGS];
  logic [REG_ADDR_WIDTH-1:0]   rd_q;
  logic [DATA_WIDTH-1:0]       op_a_c;
  logic [DATA_WIDTH-1:0]       op_b_c;

  // Operand read; register 0 reads as zero regardless of storage contents.
  always_comb begin
    op_a_c = '0;
    op_b_c = '0;
    if (CMD_RA != '0) begin
      op_a_c = regs[CMD_RA];
    end
    if (CMD_IMM_EN) begin
      op_b_c = DATA_WIDTH'(CMD_IMM);
    end else if (CMD_RB != '0) begin
      op_b_c = regs[CMD_RB];
    end
  end

  // Control FSM, register file, operand and result registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      rd_q      <= '0;
      ALU_SEL   <= '0;
      ALU_A     <= '0;
      ALU_B     <= '0;
      RES_DATA  <= '0;
      RES_ZERO  <= 1'b1;
      RES_VALID <= 1'b0;
      CMD_READY <= 1'b1;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (CMD_VALID) begin
            ALU_SEL   <= CMD_OP;
            ALU_A     <= op_a_c;
            ALU_B     <= op_b_c;
            rd_q      <= CMD_RD;
            CMD_READY <= 1'b0;
            state     <= EXEC;
          end
        end
        EXEC: begin
          // Writeback lands here, before the next accept, so no hazard logic is needed.
          RES_DATA  <= ALU_S;
          RES_ZERO  <= (ALU_S == '0);
          RES_VALID <= 1'b1;
          if (rd_q != '0) begin
            regs[rd_q] <= ALU_S;
          end
          state <= RESP;
        end
        RESP: begin
          if (RES_READY) begin
            RES_VALID <= 1'b0;
            CMD_READY <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          RES_VALID <= 1'b0;
          CMD_READY <= 1'b1;
        end
      endcase
    end
  end

endmodule
